// File: rtl/uart_frame_pkg.sv
// Shared framing definitions: state encoding and default start-of-frame marker.
// Pure declarations; no logic, no latency.
package uart_frame_pkg;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_LEN_H,
      ST_LEN_L,
      ST_PAYLOAD,
      ST_CSUM,
      ST_DONE
   } frame_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte prefetch FIFO, DEPTH entries (power of two, >= 2); head visible combinationally.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps occupancy.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/result_framer.sv
// Streams SOF, 14-bit length, NUM_DATA memory bytes and an XOR checksum to a UART.
// Each byte waits on the synchronized tx_ready level handshake; memory reads prefetch into a small FIFO.
module result_framer
   import uart_frame_pkg::*;
#(
   parameter int         NUM_DATA   = 2500,
   parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [13:0] mem_read_sel,
   input  logic [7:0]  mem_read_data,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        busy,
   output logic        finish
);
   localparam logic [13:0] LEN  = 14'(NUM_DATA);
   localparam logic [13:0] LAST = 14'(NUM_DATA - 1);

   frame_state_t state;
   logic         rdy_meta;
   logic         rdy_sync;
   logic         rd_done;
   logic [13:0]  pay_cnt;
   logic [7:0]   csum;
   logic         push;
   logic         pop;
   logic         fifo_clr;
   logic         fifo_full;
   logic         fifo_empty;
   logic [7:0]   fifo_head;
   logic [7:0]   next_byte;
   logic         byte_vld;

   // Reset to 1 so an idle transmitter is assumed until the real level arrives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdy_meta <= 1'b1;
         rdy_sync <= 1'b1;
      end else begin
         rdy_meta <= tx_ready;
         rdy_sync <= rdy_meta;
      end
   end

   assign fifo_clr = (state == ST_IDLE) && start;
   assign push     = (state inside {ST_LEN_H, ST_LEN_L, ST_PAYLOAD}) && !fifo_full && !rd_done;
   // Payload byte stays at the FIFO head until the transmitter takes it.
   assign pop      = (state == ST_PAYLOAD) && tx_start && !rdy_sync;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (fifo_clr),
      .push      (push),
      .push_data (mem_read_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_read_sel <= '0;
         rd_done      <= 1'b0;
      end else if (fifo_clr) begin
         mem_read_sel <= '0;
         rd_done      <= 1'b0;
      end else if (push) begin
         if (mem_read_sel == LAST) rd_done      <= 1'b1;
         else                      mem_read_sel <= mem_read_sel + 14'd1;
      end
   end

   always_comb begin
      next_byte = SOF_BYTE;
      byte_vld  = 1'b1;
      case (state)
         ST_LEN_H:   next_byte = {2'b00, LEN[13:8]};
         ST_LEN_L:   next_byte = LEN[7:0];
         ST_PAYLOAD: begin
            next_byte = fifo_head;
            byte_vld  = !fifo_empty;
         end
         ST_CSUM:    next_byte = csum;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         finish   <= 1'b0;
         csum     <= 8'h00;
         pay_cnt  <= '0;
      end else begin
         finish <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_SOF;
                  busy    <= 1'b1;
                  csum    <= 8'h00;
                  pay_cnt <= '0;
               end
            end
            ST_SOF, ST_LEN_H, ST_LEN_L, ST_PAYLOAD, ST_CSUM: begin
               if (!tx_start) begin
                  if (rdy_sync && byte_vld) begin
                     tx_data  <= next_byte;
                     tx_start <= 1'b1;
                  end
               end else if (!rdy_sync) begin
                  tx_start <= 1'b0;
                  case (state)
                     ST_SOF:     state <= ST_LEN_H;
                     ST_LEN_H:   state <= ST_LEN_L;
                     ST_LEN_L:   state <= ST_PAYLOAD;
                     ST_PAYLOAD: begin
                        csum    <= csum ^ tx_data;
                        pay_cnt <= pay_cnt + 14'd1;
                        if (pay_cnt == LAST) state <= ST_CSUM;
                     end
                     default: begin
                        state  <= ST_DONE;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                     end
                  endcase
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
